// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, owner encoding, wait counter width.
package mem_arb_pkg;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} arb_owner_t;
endpackage

// File: rtl/arb_pick.sv
// Owner picker for the SRAM arbiter. ARB_ROUND_ROBIN_EN selects alternating tie-break
// via a last_owner register; otherwise fixed priority DBG > CPU.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic       accept,
  output arb_owner_t owner
);

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner;

  // Starts at DBG so the first tie after reset goes to the CPU.
  always_ff @(posedge clk) begin
    if (rst)         last_owner <= OWN_DBG;
    else if (accept) last_owner <= owner;
  end

  always_comb begin
    owner = OWN_CPU;
    if (cpu_req && dbg_req) owner = (last_owner == OWN_DBG) ? OWN_CPU : OWN_DBG;
    else if (dbg_req)       owner = OWN_DBG;
  end
`else
  logic unused_pick;
  assign unused_pick = ^{clk, rst, accept, cpu_req};

  always_comb owner = dbg_req ? OWN_DBG : OWN_CPU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DBG) arbiter for one synchronous SRAM with WAIT_STATES extra cycles
// per access. Optional macro ARB_ROUND_ROBIN_EN switches tie-break to round robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic [DATA_W/8-1:0] cpu_be_i,
  output logic                cpu_gnt_o,
  output logic                cpu_done_o,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  output logic                cpu_stall_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [ADDR_W-1:0]   dbg_addr_i,
  input  logic [DATA_W-1:0]   dbg_wdata_i,
  input  logic [DATA_W/8-1:0] dbg_be_i,
  output logic                dbg_gnt_o,
  output logic                dbg_done_o,
  output logic [DATA_W-1:0]   dbg_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("mem_arbiter: WAIT_STATES must be in 0..15");
  end

  localparam logic [WCNT_W-1:0] WS = WCNT_W'(WAIT_STATES);

  arb_state_t          state, state_nx;
  arb_owner_t          owner, pick;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;
  logic                cpu_busy;
  logic                accept;
  logic                wait_last;

  assign accept    = (state == ARB_IDLE) && (cpu_req_i || dbg_req_i);
  assign wait_last = (wait_cnt == WS);

  arb_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req_i),
    .dbg_req (dbg_req_i),
    .accept  (accept),
    .owner   (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE:   if (accept)    state_nx = ARB_ACCESS;
      ARB_ACCESS: if (wait_last) state_nx = ARB_DONE;
      ARB_DONE:                  state_nx = ARB_IDLE;
      default:                   state_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_en_o = (state == ARB_ACCESS);
    mem_we_o = lat_we & (state == ARB_ACCESS);
  end

  assign mem_addr_o  = lat_addr;
  assign mem_wdata_o = lat_wdata;
  assign mem_be_o    = lat_be;
  assign cpu_stall_o = cpu_req_i | cpu_busy;

  // Request latches, wait counter and per-requester response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_CPU;
      wait_cnt    <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      cpu_busy    <= 1'b0;
      cpu_gnt_o   <= 1'b0;
      dbg_gnt_o   <= 1'b0;
      cpu_done_o  <= 1'b0;
      dbg_done_o  <= 1'b0;
      cpu_rdata_o <= '0;
      dbg_rdata_o <= '0;
    end else begin
      cpu_gnt_o  <= 1'b0;
      dbg_gnt_o  <= 1'b0;
      cpu_done_o <= 1'b0;
      dbg_done_o <= 1'b0;
      case (state)
        ARB_IDLE: if (accept) begin
          owner    <= pick;
          wait_cnt <= '0;
          if (pick == OWN_DBG) begin
            lat_we    <= dbg_we_i;
            lat_addr  <= dbg_addr_i;
            lat_wdata <= dbg_wdata_i;
            lat_be    <= dbg_be_i;
            dbg_gnt_o <= 1'b1;
          end else begin
            lat_we    <= cpu_we_i;
            lat_addr  <= cpu_addr_i;
            lat_wdata <= cpu_wdata_i;
            lat_be    <= cpu_be_i;
            cpu_gnt_o <= 1'b1;
            cpu_busy  <= 1'b1;
          end
        end
        ARB_ACCESS: if (!wait_last) wait_cnt <= wait_cnt + 1'b1;
        ARB_DONE: begin
          if (owner == OWN_DBG) begin
            dbg_done_o <= 1'b1;
            if (!lat_we) dbg_rdata_o <= mem_rdata_i;
          end else begin
            cpu_done_o <= 1'b1;
            cpu_busy   <= 1'b0;
            if (!lat_we) cpu_rdata_o <= mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table (WAIT_STATES=1) plus hand sequences for
// continuous contention, mid-access reset and a WAIT_STATES=0 instance.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, dbg_req, a_we;
  logic [15:0] a_addr;
  logic [31:0] a_wd;
  logic [3:0]  a_be;
  logic        cpu_gnt, cpu_done, cpu_stall, dbg_gnt, dbg_done;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        c0_req;
  logic        c0_gnt, c0_done, c0_stall, d0_gnt, d0_done;
  logic [31:0] c0_rdata, d0_rdata;
  logic        m0_en, m0_we;
  logic [15:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic [3:0]  m0_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(a_we), .cpu_addr_i(a_addr), .cpu_wdata_i(a_wd), .cpu_be_i(a_be),
    .cpu_gnt_o(cpu_gnt), .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(a_we), .dbg_addr_i(a_addr), .dbg_wdata_i(a_wd), .dbg_be_i(a_be),
    .dbg_gnt_o(dbg_gnt), .dbg_done_o(dbg_done), .dbg_rdata_o(dbg_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req_i(c0_req), .cpu_we_i(1'b0), .cpu_addr_i(a_addr), .cpu_wdata_i(32'h0), .cpu_be_i(4'h0),
    .cpu_gnt_o(c0_gnt), .cpu_done_o(c0_done), .cpu_rdata_o(c0_rdata), .cpu_stall_o(c0_stall),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(16'h0), .dbg_wdata_i(32'h0), .dbg_be_i(4'h0),
    .dbg_gnt_o(d0_gnt), .dbg_done_o(d0_done), .dbg_rdata_o(d0_rdata),
    .mem_en_o(m0_en), .mem_we_o(m0_we), .mem_addr_o(m0_addr), .mem_wdata_o(m0_wdata),
    .mem_be_o(m0_be), .mem_rdata_i(m0_rdata)
  );

  // Synchronous SRAM models: read data appears the cycle after an enabled cycle.
  logic [31:0] sram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[8'h10] = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    m0_rdata  = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[7:0]];
      end
    end
  end

  always @(posedge clk) if (m0_en) m0_rdata <= 32'hA5000000 | {16'h0, m0_addr};

  typedef struct {
    logic        creq, dreq, we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [6:0]  ctl;   // {cpu_gnt, cpu_done, dbg_gnt, dbg_done, cpu_stall, mem_en, mem_we}
    logic [3:0]  ebe;
    logic [31:0] crd, drd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic cr, logic dr, logic we, logic [15:0] a, logic [31:0] wd,
                              logic [3:0] be, logic [6:0] ctl, logic [3:0] ebe,
                              logic [31:0] crd, logic [31:0] drd);
    vec_t v;
    v.creq = cr; v.dreq = dr; v.we = we; v.addr = a; v.wd = wd; v.be = be;
    v.ctl = ctl; v.ebe = ebe; v.crd = crd; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    tick();
    cpu_req = v.creq; dbg_req = v.dreq; a_we = v.we; a_addr = v.addr; a_wd = v.wd; a_be = v.be;
    @(negedge clk);
    chk($sformatf("row%0d ctl", idx),
        {25'h0, cpu_gnt, cpu_done, dbg_gnt, dbg_done, cpu_stall, mem_en, mem_we}, {25'h0, v.ctl});
    chk($sformatf("row%0d be", idx), {28'h0, mem_be}, {28'h0, v.ebe});
    chk($sformatf("row%0d cpu_rdata", idx), cpu_rdata, v.crd);
    chk($sformatf("row%0d dbg_rdata", idx), dbg_rdata, v.drd);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] WV = 32'h12345678;
  localparam logic [31:0] RB = 32'h00005678;

  initial begin
    int          ng;
    logic [3:0]  order;
    logic [3:0]  exp_order;
    logic        stall_ok;
    logic [2:0]  pat [0:7];

    // idle, CPU read of 0x10
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000000, 0, 0, 0));
    tv.push_back(mk(1,0,0,16'h10,0,0, 7'b0000100, 0, 0, 0));
    tv.push_back(mk(1,0,0,16'h10,0,0, 7'b1000110, 0, 0, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000110, 0, 0, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000100, 0, 0, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0100000, 0, DB, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000000, 0, DB, 0));
    // DBG partial write to 0x20, then DBG readback
    tv.push_back(mk(0,1,1,16'h20,WV,4'b0011, 7'b0000000, 0, DB, 0));
    tv.push_back(mk(0,1,1,16'h20,WV,4'b0011, 7'b0010011, 3, DB, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000011, 3, DB, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000000, 3, DB, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0001000, 3, DB, 0));
    tv.push_back(mk(0,1,0,16'h20,0,0, 7'b0000000, 3, DB, 0));
    tv.push_back(mk(0,1,0,16'h20,0,0, 7'b0010010, 0, DB, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000010, 0, DB, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000000, 0, DB, 0));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0001000, 0, DB, RB));
    // simultaneous requests, both reading 0x10
`ifdef ARB_ROUND_ROBIN_EN
    tv.push_back(mk(1,1,0,16'h10,0,0, 7'b0000100, 0, DB, RB));
    tv.push_back(mk(1,1,0,16'h10,0,0, 7'b1000110, 0, DB, RB));
    tv.push_back(mk(0,1,0,16'h10,0,0, 7'b0000110, 0, DB, RB));
    tv.push_back(mk(0,1,0,16'h10,0,0, 7'b0000100, 0, DB, RB));
    tv.push_back(mk(0,1,0,16'h10,0,0, 7'b0100000, 0, DB, RB));
    tv.push_back(mk(0,1,0,16'h10,0,0, 7'b0010010, 0, DB, RB));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000010, 0, DB, RB));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000000, 0, DB, RB));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0001000, 0, DB, DB));
`else
    tv.push_back(mk(1,1,0,16'h10,0,0, 7'b0000100, 0, DB, RB));
    tv.push_back(mk(1,1,0,16'h10,0,0, 7'b0010110, 0, DB, RB));
    tv.push_back(mk(1,0,0,16'h10,0,0, 7'b0000110, 0, DB, RB));
    tv.push_back(mk(1,0,0,16'h10,0,0, 7'b0000100, 0, DB, RB));
    tv.push_back(mk(1,0,0,16'h10,0,0, 7'b0001100, 0, DB, DB));
    tv.push_back(mk(1,0,0,16'h10,0,0, 7'b1000110, 0, DB, DB));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000110, 0, DB, DB));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0000100, 0, DB, DB));
    tv.push_back(mk(0,0,0,16'h00,0,0, 7'b0100000, 0, DB, DB));
`endif

    // reset: outputs zero, stall follows cpu_req only
    rst = 1'b1; cpu_req = 1'b1; dbg_req = 1'b0; c0_req = 1'b0;
    a_we = 1'b0; a_addr = 16'h0; a_wd = 32'h0; a_be = 4'h0;
    tick(); tick();
    @(negedge clk);
    chk("reset outs", {26'h0, cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_en, mem_we}, 32'h0);
    chk("reset rdata", cpu_rdata | dbg_rdata | {16'h0, mem_addr} | mem_wdata | {28'h0, mem_be}, 32'h0);
    chk("reset stall=req", {31'h0, cpu_stall}, 32'h1);
    cpu_req = 1'b0;
    #1;
    chk("reset stall low", {31'h0, cpu_stall}, 32'h0);
    tick();
    rst = 1'b0;

    foreach (tv[i]) apply(i, tv[i]);

    // both requests held continuously for four grants
    tick();
    cpu_req = 1'b1; dbg_req = 1'b1; a_we = 1'b0; a_addr = 16'h10;
    ng = 0; order = 4'h0; stall_ok = 1'b1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (!cpu_stall) stall_ok = 1'b0;
      if (cpu_gnt)      begin order[ng] = 1'b0; ng++; end
      else if (dbg_gnt) begin order[ng] = 1'b1; ng++; end
      tick();
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    chk("contend grant count", ng, 4);
    chk("contend order", {28'h0, order}, {28'h0, exp_order});
    chk("contend stall held", {31'h0, stall_ok}, 32'h1);
    cpu_req = 1'b0; dbg_req = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    // reset in the second ACCESS cycle abandons the access
    cpu_req = 1'b1; a_addr = 16'h10;
    tick();
    @(negedge clk); chk("rst gnt", {31'h0, cpu_gnt}, 32'h1);
    cpu_req = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk); chk("rst access2 en", {31'h0, mem_en}, 32'h1);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst after", {27'h0, mem_en, cpu_gnt, cpu_done, cpu_stall, dbg_done}, 32'h0);
    chk("rst rdata", cpu_rdata, 32'h0);
    tick(); @(negedge clk); chk("rst no done1", {31'h0, cpu_done}, 32'h0);
    tick(); @(negedge clk); chk("rst no done2", {31'h0, cpu_done}, 32'h0);
    tick(); cpu_req = 1'b1;
    tick(); @(negedge clk); chk("rst fresh gnt", {31'h0, cpu_gnt}, 32'h1);
    cpu_req = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst fresh done", {31'h0, cpu_done}, 32'h1);
    chk("rst fresh rdata", cpu_rdata, DB);

    // zero wait states: back-to-back reads with request held
    pat[0] = 3'b000; pat[1] = 3'b101; pat[2] = 3'b000; pat[3] = 3'b010;
    pat[4] = 3'b101; pat[5] = 3'b000; pat[6] = 3'b010; pat[7] = 3'b101;
    tick();
    c0_req = 1'b1; a_addr = 16'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("ws0 cyc%0d gnt/done/en", i), {29'h0, c0_gnt, c0_done, m0_en}, {29'h0, pat[i]});
      if (i == 3) chk("ws0 rdata", c0_rdata, 32'hA5000010);
      tick();
    end
    c0_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
